disp_time_formatter: RTL



---
 rtl/disp_time_formatter_if.sv | 21 ++
 rtl/disp_time_formatter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/disp_time_formatter_if.sv
// Request/response bundle between the time core and the display formatter.
// The master drives time and load requests; the slave returns characters and status.
interface disp_time_formatter_if;
    logic [4:0]  i_hours;
    logic [5:0]  i_minutes;
    logic        i_load;
    logic [1:0]  i_blink_sel;
    logic [31:0] o_data;
    logic        o_busy;
    logic        o_valid;

    modport master (
        output i_hours, i_minutes, i_load, i_blink_sel,
        input  o_data, o_busy, o_valid
    );

    modport slave (
        input  i_hours, i_minutes, i_load, i_blink_sel,
        output o_data, o_busy, o_valid
    );
endinterface

// File: rtl/disp_time_formatter.sv
// Binary hh:mm to four ASCII bytes via repeated subtraction by 10, with
// per-field blink blanking for set-mode editing.
module disp_time_formatter #(
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    disp_time_formatter_if.slave  bus
);
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV_H, CONV_M, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rem_h_q, rem_h_d;
    logic [5:0]  rem_m_q, rem_m_d;
    logic [1:0]  tens_h_q, tens_h_d;
    logic [2:0]  tens_m_q, tens_m_d;
    logic        inv_h_q, inv_h_d;
    logic        inv_m_q, inv_m_d;
    logic [31:0] char_q, char_d;
    logic        valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic [15:0] hours_chars, mins_chars;
    logic [31:0] data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rem_h_q  <= '0;
            rem_m_q  <= '0;
            tens_h_q <= '0;
            tens_m_q <= '0;
            inv_h_q  <= 1'b0;
            inv_m_q  <= 1'b0;
            char_q   <= 32'h3030_3030;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_h_q  <= rem_h_d;
            rem_m_q  <= rem_m_d;
            tens_h_q <= tens_h_d;
            tens_m_q <= tens_m_d;
            inv_h_q  <= inv_h_d;
            inv_m_q  <= inv_m_d;
            char_q   <= char_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    // Remainders are below 10 once conversion finishes, so only the low nibble matters.
    assign hours_chars = inv_h_q ? 16'h2D2D :
                         {8'h30 + {6'd0, tens_h_q}, 8'h30 + {4'd0, rem_h_q[3:0]}};
    assign mins_chars  = inv_m_q ? 16'h2D2D :
                         {8'h30 + {5'd0, tens_m_q}, 8'h30 + {4'd0, rem_m_q[3:0]}};

    always_comb begin
        state_d  = state_q;
        rem_h_d  = rem_h_q;
        rem_m_d  = rem_m_q;
        tens_h_d = tens_h_q;
        tens_m_d = tens_m_q;
        inv_h_d  = inv_h_q;
        inv_m_d  = inv_m_q;
        char_d   = char_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_load) begin
                    rem_h_d  = bus.i_hours;
                    rem_m_d  = bus.i_minutes;
                    tens_h_d = '0;
                    tens_m_d = '0;
                    inv_h_d  = bus.i_hours > 5'd23;
                    inv_m_d  = bus.i_minutes > 6'd59;
                    state_d  = CONV_H;
                end
            end
            CONV_H: begin
                if (!inv_h_q && rem_h_q >= 5'd10) begin
                    rem_h_d  = rem_h_q - 5'd10;
                    tens_h_d = tens_h_q + 2'd1;
                end else begin
                    state_d = CONV_M;
                end
            end
            CONV_M: begin
                if (!inv_m_q && rem_m_q >= 6'd10) begin
                    rem_m_d  = rem_m_q - 6'd10;
                    tens_m_d = tens_m_q + 3'd1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                char_d  = {hours_chars, mins_chars};
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (cnt_q == CW'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        data = char_q;
        if (phase_q && bus.i_blink_sel[1]) data[31:16] = 16'h2020;
        if (phase_q && bus.i_blink_sel[0]) data[15:0]  = 16'h2020;
    end

    assign bus.o_data  = data;
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_valid = valid_q;
endmodule
